pending_priority_encoder: RTL and testbench
===========================================

Name: pending_priority_encoder

Overview:
- Parametrised, registered successor to the team's 16-to-4 combinational encoder.
- Latches request pulses into a pending vector and presents the winning index on a valid/ready output, one index per handshake.
- Clears each served bit and flags requests lost to an already-pending bit.
- Sits between event sources (interrupt/request lines) and a consumer that services one index at a time.

Parameters:
- N, 16, number of request inputs (N >= 2).
- W, $clog2(N), index width; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  enable; low blocks capture and serving.
- req  input  N  request pulses; a bit high on a sampled edge sets the matching pending bit.
- y  output  W  index being presented.
- valid  output  1  y holds a pending index.
- ready  input  1  consumer accepts y when valid && ready at an edge.
- pending  output  N  current pending vector (registered).
- overflow  output  1  one-cycle pulse: a request hit an already-pending bit.

Behaviour:
- One clock, clk; reset is asynchronous and active-low on rst_n.
- Reset, asynchronous and any time including mid-stall: pending=0, y=0, valid=0, overflow=0, round-robin pointer=N-1.
- Handshake: an edge with valid && ready && en.
- clear: one-hot of y on a handshake edge, else 0.
- set: req when en=1, else 0.
- P_next = (pending & ~clear) | set. On the same bit, set wins, so the index is re-served later.
- Output register update, every edge:
  - en=0: valid<=0, y unchanged, pending retained (no capture, no clear).
  - Stall (valid=1, ready=0, en=1): y and valid hold. New arrivals, including higher-priority ones, only update pending.
  - Otherwise: valid <= |P_next and y <= encode(P_next). When P_next==0, y holds its value.
- Latency: a req bit sampled at edge k gives valid=1 after edge k, if not stalled.
- Throughput: one index per cycle with ready held high. The bit served at edge k is absent from the next choice unless it was re-set.
- Fixed-priority encode: highest set index wins.
- overflow: registered, high for the cycle after edge k iff en=1 and (req & pending & ~clear) != 0 at edge k.
- Width: y is W bits; index N-1 fits exactly. Non-power-of-2 N: index codes >= N never appear.

Optional Feature:
- Macro: PPE_ROUND_ROBIN_EN.
- Defined:
  - encode() searches upward from (ptr+1) mod N, wrapping, and picks the first set bit.
  - ptr <= y on each handshake edge.
  - ptr resets to N-1, so the first search starts at index 0.
  - ptr does not change on stall or en=0.
- Undefined: fixed highest-index priority as above. No pointer register is synthesised.

Test Plan:
1. Reset: assert rst_n=0 mid-stall with pending=16'h00F0 -> y=0, valid=0, pending=0, overflow=0 immediately, with no clock edge needed.
2. N=16, fixed: req=16'h8421 for one edge, ready=1 -> y=15,10,5,0 on four consecutive cycles with valid=1, then valid=0 and pending=0.
3. Stall: req=16'h0003, ready=0 -> y=1 held. Pulse req bit15 during the stall -> y stays 1 and pending=16'h8003. Raise ready -> y=1, then 15, then 0 are served.
4. Overflow: bit4 pending, ready=0, pulse req bit4 -> overflow=1 for exactly one cycle and pending unchanged. Bit4 set and cleared on the same edge -> overflow=0 and bit4 remains pending.
5. Enable: en=0, req=16'hFFFF -> pending unchanged, valid=0. Set en=1 with the earlier pending=16'h0100 -> valid=1, y=8 after the next edge.
6. PPE_ROUND_ROBIN_EN, req=16'h8001 held every cycle, ready=1 -> y alternates 0,15,0,15. Without the macro -> y=15 every cycle.

Source files
------------

// File: rtl/pending_priority_encoder.sv
// Registered pending-request priority encoder with a valid/ready index output.
// Define PPE_ROUND_ROBIN_EN to replace fixed highest-index priority with round-robin search.
module pending_priority_encoder #(
  parameter  int N = 16,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [W-1:0] y,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  localparam int unsigned NU = N;

  logic         hs;
  logic [N-1:0] clear;
  logic [N-1:0] set;
  logic [N-1:0] p_next;
  logic         any;
  logic         ovf_next;
  logic [W-1:0] enc;

`ifdef PPE_ROUND_ROBIN_EN
  logic [W-1:0] ptr;
  logic [W-1:0] base;
`endif

  always_comb begin
    hs = valid & ready & en;
    clear = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      clear[i] = hs && (y == W'(i));
    end
    set      = en ? req : '0;
    p_next   = (pending & ~clear) | set;
    any      = |p_next;
    ovf_next = en && (|(req & pending & ~clear));
  end

`ifdef PPE_ROUND_ROBIN_EN
  // The search base follows the index being served this edge so the next
  // choice starts just above it, even before ptr itself has been updated.
  always_comb begin
    int unsigned idx;
    base = hs ? y : ptr;
    enc  = '0;
    idx  = 0;
    for (int unsigned k = NU; k >= 1; k--) begin
      idx = (32'(base) + k) % NU;
      if (p_next[idx]) enc = W'(idx);
    end
  end
`else
  always_comb begin
    enc = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (p_next[i]) enc = W'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      y        <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
`ifdef PPE_ROUND_ROBIN_EN
      ptr      <= W'(N - 1);
`endif
    end else begin
      pending  <= p_next;
      overflow <= ovf_next;
      if (!en) begin
        valid <= 1'b0;
      end else if (!(valid && !ready)) begin
        valid <= any;
        if (any) y <= enc;
      end
`ifdef PPE_ROUND_ROBIN_EN
      if (hs) ptr <= y;
`endif
    end
  end

endmodule

// File: tb/tb_pending_priority_encoder.sv
// Self-checking bench for pending_priority_encoder: directed scenarios plus
// randomized traffic checked against a bit-array reference model.
module tb_pending_priority_encoder;

  localparam int N = 16;
  localparam int W = 4;
`ifdef PPE_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef bit vec_t [N];

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         ready;
  logic [N-1:0] req;
  logic [W-1:0] y;
  logic         valid;
  logic [N-1:0] pending;
  logic         overflow;

  pending_priority_encoder #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .req      (req),
    .y        (y),
    .valid    (valid),
    .ready    (ready),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  vec_t m_pend;
  int   m_y;
  bit   m_valid;
  bit   m_ovf;
  int   m_ptr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick_fixed(vec_t p);
    for (int i = N - 1; i >= 0; i--) if (p[i]) return i;
    return -1;
  endfunction

  function automatic int pick_rr(vec_t p, int base);
    for (int k = 1; k <= N; k++) if (p[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    for (int b = 0; b < N; b++) v[b] = m_pend[b];
    return v;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < N; b++) m_pend[b] = 1'b0;
    m_y = 0; m_valid = 1'b0; m_ovf = 1'b0; m_ptr = N - 1;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input bit e, input bit rd);
    bit   hs;
    bit   clr;
    bit   ov;
    vec_t np;
    int   w;
    int   old_y;
    hs = m_valid && rd && e;
    ov = 1'b0;
    old_y = m_y;
    for (int b = 0; b < N; b++) begin
      clr   = hs && (b == m_y);
      np[b] = (e && r[b]) || (m_pend[b] && !clr);
      if (e && r[b] && m_pend[b] && !clr) ov = 1'b1;
    end
    w = RR ? pick_rr(np, hs ? m_y : m_ptr) : pick_fixed(np);
    if (!e) m_valid = 1'b0;
    else if (!(m_valid && !rd)) begin
      m_valid = (w >= 0);
      if (w >= 0) m_y = w;
    end
    if (hs) m_ptr = old_y;
    m_pend = np;
    m_ovf  = ov;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".y"},        32'(y),        32'(m_y));
    check({tag, ".valid"},    32'(valid),    32'(m_valid));
    check({tag, ".pending"},  32'(pending),  32'(pend_vec()));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Drive inputs before the edge, advance model, compare 1 time unit later.
  task automatic step(input string tag, input logic [N-1:0] r, input bit e, input bit rd);
    req = r; en = e; ready = rd;
    @(posedge clk);
    model_edge(r, e, rd);
    #1;
    compare_all(tag);
  endtask

  // Called at posedge+1; reset asserts between edges and releases before the next.
  task automatic areset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_y"},        32'(y),        32'd0);
    check({tag, ".rst_valid"},    32'(valid),    32'd0);
    check({tag, ".rst_pending"},  32'(pending),  32'd0);
    check({tag, ".rst_overflow"}, 32'(overflow), 32'd0);
    #3 rst_n = 1'b1;
  endtask

  int seq2 [4];

  initial begin
    rst_n = 1'b0; en = 1'b0; ready = 1'b0; req = '0;
    model_reset();
    #1;
    compare_all("por");
    #6 rst_n = 1'b1;

    // Reset mid-stall
    step("t1a", 16'h00F0, 1'b1, 1'b0);
    step("t1b", 16'h0000, 1'b1, 1'b0);
    check("t1.pending_before", 32'(pending), 32'h00F0);
    areset("t1");

    // Four-bit burst served one per cycle
    if (RR) seq2 = '{0, 5, 10, 15};
    else    seq2 = '{15, 10, 5, 0};
    step("t2a", 16'h8421, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("t2.seq_y", 32'(y), 32'(seq2[i]));
      check("t2.seq_valid", 32'(valid), 32'd1);
      step("t2b", 16'h0000, 1'b1, 1'b1);
    end
    check("t2.end_valid", 32'(valid), 32'd0);
    check("t2.end_pending", 32'(pending), 32'd0);

    // Stall holds y while a higher-priority bit arrives
    areset("t3r");
    step("t3a", 16'h0003, 1'b1, 1'b0);
    step("t3b", 16'h8000, 1'b1, 1'b0);
    check("t3.pending", 32'(pending), 32'h8003);
    if (!RR) check("t3.held_y", 32'(y), 32'd1);
    step("t3c", 16'h0000, 1'b1, 1'b1);
    if (!RR) check("t3.next_y", 32'(y), 32'd15);
    step("t3d", 16'h0000, 1'b1, 1'b1);
    if (!RR) check("t3.last_y", 32'(y), 32'd0);
    step("t3e", 16'h0000, 1'b1, 1'b1);

    // Overflow pulse, and set-wins-over-clear without overflow
    step("t4a", 16'h0010, 1'b1, 1'b0);
    step("t4b", 16'h0010, 1'b1, 1'b0);
    check("t4.ovf_pulse", 32'(overflow), 32'd1);
    step("t4c", 16'h0000, 1'b1, 1'b0);
    check("t4.ovf_one_cycle", 32'(overflow), 32'd0);
    step("t4d", 16'h0010, 1'b1, 1'b1);
    check("t4.setclr_ovf", 32'(overflow), 32'd0);
    check("t4.setclr_pending", 32'(pending), 32'h0010);
    step("t4e", 16'h0000, 1'b1, 1'b1);

    // Enable low blocks capture and serving
    step("t5a", 16'h0100, 1'b1, 1'b0);
    step("t5b", 16'hFFFF, 1'b0, 1'b1);
    check("t5.en0_pending", 32'(pending), 32'h0100);
    check("t5.en0_valid", 32'(valid), 32'd0);
    step("t5c", 16'h0000, 1'b1, 1'b1);
    check("t5.en1_y", 32'(y), 32'd8);
    check("t5.en1_valid", 32'(valid), 32'd1);
    step("t5d", 16'h0000, 1'b1, 1'b1);

    // Two requests held continuously
    areset("t6r");
    for (int i = 0; i < 6; i++) begin
      step("t6", 16'h8001, 1'b1, 1'b1);
      check("t6.y", 32'(y), RR ? ((i % 2 == 0) ? 32'd0 : 32'd15) : 32'd15);
    end
    step("t6z", 16'h0000, 1'b1, 1'b1);
    step("t6z", 16'h0000, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      r = N'($urandom() & $urandom() & $urandom());
      if ($urandom_range(0, 5) == 0) r = '0;
      step("rnd", r, $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7);
      if ($urandom_range(0, 149) == 0) areset("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
